// File: rtl/fir_ctrl_if.sv
// fir_ctrl_if: output sample stream of the FIR controller.
// Plain valid/ready handshake carrying one filtered sample per beat.
interface fir_ctrl_if #(
  parameter int OUT_W = 20
);
  logic             m_valid;
  logic             m_ready;
  logic [OUT_W-1:0] m_data;

  modport master (
    output m_valid,
    output m_data,
    input  m_ready
  );

  modport slave (
    input  m_valid,
    input  m_data,
    output m_ready
  );
endinterface

// File: rtl/fir_ctrl.sv
// fir_ctrl: run/stop controller for the 16-tap symmetric FIR.
// Sample divider, fill blanking, drain FSM and 2-deep output buffer.
module fir_ctrl #(
  parameter int DIV_W    = 16,
  parameter int FILL_CNT = 16,
  parameter int OUT_W    = 20
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic             stop,
  input  logic             bypass,
  input  logic [DIV_W-1:0] div,
  input  logic [7:0]       adc_data,
  output logic             fir_en,
  output logic [7:0]       fir_xin,
  input  logic             fir_valid,
  input  logic [OUT_W-1:0] fir_yout,
  fir_ctrl_if.master       m_if,
  output logic             ovf,
  output logic             busy,
  output logic [1:0]       state
);

  localparam int FW = $clog2(FILL_CNT + 1);
  localparam logic [FW-1:0] FILL_LAST = FW'(FILL_CNT - 1);
  localparam logic [FW-1:0] FILL_MAX  = FW'(FILL_CNT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } st_t;

  st_t              st_q, st_d;
  logic [DIV_W-1:0] div_q, cnt_q;
  logic             byp_q;
  logic [FW-1:0]    fill_q;
  logic [3:0]       outst_q;
  logic [1:0]       bcnt_q;
  logic [OUT_W-1:0] head_q, tail_q;

  logic             active, hit, fill_done;
  logic             push_fir, push_byp, push;
  logic             pop, full, accept, drop;
  logic             inc, dec;
  logic [OUT_W-1:0] din;

  assign active    = (st_q == FILL) || (st_q == RUN);
  assign hit       = active && !stop && (cnt_q == div_q);
  assign fill_done = (fill_q == FILL_MAX);

  // FIR results only count once fill is over; bypass feeds raw samples
  assign push_fir = fir_valid && !byp_q &&
                    ((st_q == RUN) || ((st_q == DRAIN) && fill_done));
  assign push_byp = hit && byp_q;
  assign push     = push_fir || push_byp;
  assign din      = push_byp ? {adc_data, {(OUT_W-8){1'b0}}} : fir_yout;

  assign pop    = m_if.m_valid && m_if.m_ready;
  assign full   = (bcnt_q == 2'd2);
  assign accept = push && (!full || pop);
  assign drop   = push && full && !pop;

  assign inc = fir_en;
  assign dec = fir_valid && (outst_q != 4'd0);

  assign m_if.m_valid = (bcnt_q != 2'd0);
  assign m_if.m_data  = head_q;
  assign state        = st_q;
  assign busy         = (st_q != IDLE);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) st_q <= IDLE;
    else       st_q <= st_d;
  end

  always_comb begin
    st_d = st_q;
    unique case (st_q)
      IDLE: begin
        if (start) st_d = bypass ? RUN : FILL;
      end
      FILL: begin
        if (stop)
          st_d = DRAIN;
        else if (fir_valid && (fill_q == FILL_LAST))
          st_d = RUN;
      end
      RUN: begin
        if (stop) st_d = DRAIN;
      end
      DRAIN: begin
        if ((outst_q == 4'd0) && (bcnt_q == 2'd0)) st_d = IDLE;
      end
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fir_en  <= 1'b0;
      fir_xin <= '0;
      div_q   <= '0;
      byp_q   <= 1'b0;
      cnt_q   <= '0;
      fill_q  <= '0;
      outst_q <= '0;
      ovf     <= 1'b0;
    end else begin
      fir_en <= hit;
      if (hit) fir_xin <= adc_data;
      if ((st_q == IDLE) && start) begin
        div_q  <= div;
        byp_q  <= bypass;
        cnt_q  <= '0;
        fill_q <= '0;
        ovf    <= 1'b0;
      end else begin
        if (hit)         cnt_q <= '0;
        else if (active) cnt_q <= cnt_q + DIV_W'(1);
        if ((st_q == FILL) && fir_valid) fill_q <= fill_q + FW'(1);
        if (drop) ovf <= 1'b1;
      end
      if (inc && !dec)      outst_q <= outst_q + 4'd1;
      else if (dec && !inc) outst_q <= outst_q - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bcnt_q <= '0;
      head_q <= '0;
      tail_q <= '0;
    end else begin
      unique case (1'b1)
        pop && accept: begin
          if (full) begin
            head_q <= tail_q;
            tail_q <= din;
          end else begin
            head_q <= din;
          end
        end
        pop && !accept: begin
          head_q <= tail_q;
          bcnt_q <= bcnt_q - 2'd1;
        end
        !pop && accept: begin
          if (bcnt_q == 2'd0) head_q <= din;
          else                tail_q <= din;
          bcnt_q <= bcnt_q + 2'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_ctrl.sv
// tb_fir_ctrl: directed bench for fir_ctrl with a fixed-latency FIR stub
// and a transaction-level model checked every cycle.
module tb_fir_ctrl;

  localparam int FILL = 16;
  localparam int LAT  = 5;

  logic        clk;
  logic        rstn;
  logic        start, stop, bypass;
  logic [15:0] div;
  logic [7:0]  adc_data;
  logic        fir_en;
  logic [7:0]  fir_xin;
  logic        fir_valid;
  logic [19:0] fir_yout;
  logic        ovf, busy;
  logic [1:0]  state;

  fir_ctrl_if #(.OUT_W(20)) mif ();

  fir_ctrl #(
    .DIV_W(16),
    .FILL_CNT(FILL),
    .OUT_W(20)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .start(start),
    .stop(stop),
    .bypass(bypass),
    .div(div),
    .adc_data(adc_data),
    .fir_en(fir_en),
    .fir_xin(fir_xin),
    .fir_valid(fir_valid),
    .fir_yout(fir_yout),
    .m_if(mif.master),
    .ovf(ovf),
    .busy(busy),
    .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // FIR stub: result LAT cycles after each strobe, tagged with serial and sample
  logic [LAT-1:0] vp = '0;
  logic [19:0]    yp [LAT];
  logic [7:0]     ser = '0;
  initial for (int i = 0; i < LAT; i++) yp[i] = '0;

  always @(posedge clk) begin
    vp    <= {vp[LAT-2:0], fir_en};
    yp[0] <= {4'hA, ser, fir_xin};
    for (int i = 1; i < LAT; i++) yp[i] <= yp[i-1];
    if (!rstn)       ser <= '0;
    else if (fir_en) ser <= ser + 8'd1;
  end
  assign fir_valid = vp[LAT-1];
  assign fir_yout  = yp[LAT-1];

  // observation counters and delivered samples
  int          en_cnt = 0, val_cnt = 0, dlv_cnt = 0, mv_cnt = 0;
  logic [19:0] got [$];

  always @(posedge clk) begin
    en_cnt  += int'(fir_en);
    val_cnt += int'(fir_valid);
    mv_cnt  += int'(mif.m_valid);
    if (mif.m_valid && mif.m_ready) begin
      dlv_cnt++;
      got.push_back(mif.m_data);
    end
  end

  // behavioural model: strobes by period arithmetic, buffer as a queue
  int          ms, mph, mfill, mout;
  bit          mbyp, movf, men;
  logic [15:0] mdiv;
  logic [7:0]  mxin;
  logic [19:0] mq [$];

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ms = 0; mph = 0; mfill = 0; mout = 0;
      mbyp = 0; movf = 0; men = 0; mdiv = '0; mxin = '0;
      mq.delete();
    end else begin
      bit          act, stb, push, pop;
      int          nst, sz;
      logic [19:0] pd;
      act  = (ms == 1) || (ms == 2);
      nst  = ms;
      stb  = 0;
      push = 0;
      pd   = '0;
      sz   = mq.size();
      if (act) begin
        mph++;
        stb = !stop && ((mph % (int'(mdiv) + 1)) == 0);
      end
      if (ms == 0 && start) begin
        nst = bypass ? 2 : 1;
        mbyp = bypass; mdiv = div; mph = 0; mfill = 0; movf = 0;
      end
      if (act && stop) nst = 3;
      if (fir_valid && ms != 0) begin
        if (ms == 1) begin
          mfill++;
          if (mfill == FILL && !stop) nst = 2;
        end else if (!mbyp && (ms == 2 || mfill >= FILL)) begin
          push = 1;
          pd = fir_yout;
        end
      end
      if (stb && mbyp) begin
        push = 1;
        pd = {adc_data, 12'h000};
      end
      if (ms == 3 && mout == 0 && sz == 0) nst = 0;
      if (men && !(fir_valid && mout > 0)) mout++;
      else if (!men && fir_valid && mout > 0) mout--;
      pop = (sz > 0) && mif.m_ready;
      if (pop) void'(mq.pop_front());
      if (push) begin
        if (sz < 2 || pop) mq.push_back(pd);
        else movf = 1;
      end
      men = stb;
      if (stb) mxin = adc_data;
      ms = nst;
    end
  end

  bit chk_on = 0;
  always @(negedge clk) begin
    if (chk_on) begin
      chk("state", 32'(state), 32'(ms));
      chk("busy", 32'(busy), 32'(ms != 0));
      chk("fir_en", 32'(fir_en), 32'(men));
      chk("fir_xin", 32'(fir_xin), 32'(mxin));
      chk("m_valid", 32'(mif.m_valid), 32'(mq.size() != 0));
      if (mq.size() != 0) chk("m_data", 32'(mif.m_data), 32'(mq[0]));
      chk("ovf", 32'(ovf), 32'(movf));
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (state != 2'd0 && k < budget) begin
      tick();
      k++;
    end
    chk("idle_timeout", 32'(state), 32'd0);
  endtask

  task automatic pulse_stop;
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, nv, bd, be, vb, mb;
    rstn = 1'b1;
    start = 0; stop = 0; bypass = 0; div = '0; adc_data = '0;
    mif.m_ready = 1'b1;
    #2 rstn = 1'b0;
    #1;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_fir_en", 32'(fir_en), 32'd0);
    chk("rst_m_valid", 32'(mif.m_valid), 32'd0);
    chk("rst_m_data", 32'(mif.m_data), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk_on = 1;
    repeat (2) tick();
    rstn = 1'b1;
    tick();

    // div=3 with fill blanking
    div = 16'd3; bypass = 0; adc_data = 8'h3C;
    start = 1; tick(); start = 0;
    chk("t1_state_fill", 32'(state), 32'd1);
    k = 0;
    while (!fir_en && k < 20) begin tick(); k++; end
    chk("t1_first_en", 32'(k), 32'd4);
    nv = 0; k = 0;
    while (k < 400) begin
      tick(); k++;
      if (fir_valid) begin
        nv++;
        if (nv == 17) break;
      end
    end
    chk("t1_17th_seen", 32'(nv), 32'd17);
    chk("t1_state_run", 32'(state), 32'd2);
    tick();
    chk("t1_mvalid", 32'(mif.m_valid), 32'd1);
    chk("t1_mdata", 32'(mif.m_data), 32'h000A_103C);
    repeat (10) tick();
    pulse_stop();
    wait_idle(200);

    // bypass ramp, div=0
    got.delete();
    div = 16'd0; bypass = 1; adc_data = 8'd0;
    start = 1; tick(); start = 0;
    chk("t2_state_run", 32'(state), 32'd2);
    for (int n = 0; n < 10; n++) begin
      adc_data = 8'(n);
      tick();
    end
    pulse_stop();
    wait_idle(100);
    chk("t2_count", 32'(got.size()), 32'd10);
    for (int i = 0; i < got.size() && i < 10; i++)
      chk("t2_data", 32'(got[i]), 32'(20'(i) << 12));

    // overflow with m_ready low
    got.delete();
    mif.m_ready = 1'b0;
    div = 16'd0; bypass = 1; adc_data = 8'h10;
    start = 1; tick(); start = 0;
    tick();
    adc_data = 8'h11; tick();
    adc_data = 8'h12; tick();
    chk("t3_ovf_set", 32'(ovf), 32'd1);
    chk("t3_head", 32'(mif.m_data), 32'h0001_0000);
    pulse_stop();
    chk("t3_drain", 32'(state), 32'd3);
    mif.m_ready = 1'b1;
    wait_idle(100);
    chk("t3_count", 32'(got.size()), 32'd2);
    if (got.size() == 2) begin
      chk("t3_first", 32'(got[0]), 32'h0001_0000);
      chk("t3_second", 32'(got[1]), 32'h0001_1000);
    end
    chk("t3_ovf_sticky", 32'(ovf), 32'd1);
    bypass = 0;
    start = 1; tick(); start = 0;
    chk("t3_ovf_clr", 32'(ovf), 32'd0);
    pulse_stop();
    wait_idle(100);

    // stop in RUN with three results in flight
    div = 16'd1; bypass = 0; adc_data = 8'h55;
    start = 1; tick(); start = 0;
    k = 0;
    while (state != 2'd2 && k < 200) begin tick(); k++; end
    chk("t4_reach_run", 32'(state), 32'd2);
    repeat (6) tick();
    k = 0;
    while ((en_cnt + int'(fir_en) - val_cnt) != 3 && k < 20) begin
      tick(); k++;
    end
    chk("t4_pending", 32'(en_cnt + int'(fir_en) - val_cnt), 32'd3);
    pulse_stop();
    bd = dlv_cnt; be = en_cnt;
    wait_idle(100);
    chk("t4_delivered", 32'(dlv_cnt - bd), 32'd3);
    chk("t4_no_strobe", 32'(en_cnt - be), 32'd0);

    // stop during fill after 5 results
    div = 16'd0; bypass = 0;
    start = 1; tick(); start = 0;
    vb = val_cnt; mb = mv_cnt; k = 0;
    while ((val_cnt - vb) < 5 && k < 100) begin tick(); k++; end
    chk("t5_five_valid", 32'(val_cnt - vb), 32'd5);
    pulse_stop();
    chk("t5_drain", 32'(state), 32'd3);
    wait_idle(100);
    chk("t5_no_mvalid", 32'(mv_cnt - mb), 32'd0);

    // start beats stop from IDLE
    div = 16'd2; bypass = 0;
    start = 1; stop = 1; tick(); start = 0; stop = 0;
    chk("t6_start_wins", 32'(state), 32'd1);
    pulse_stop();
    wait_idle(100);

    // reset in RUN with a full buffer
    mif.m_ready = 1'b0;
    div = 16'd0; bypass = 1; adc_data = 8'h77;
    start = 1; tick(); start = 0;
    repeat (3) tick();
    chk("t7_run", 32'(state), 32'd2);
    chk("t7_full", 32'(mif.m_valid), 32'd1);
    #2 rstn = 1'b0;
    #1;
    chk("t7_rst_state", 32'(state), 32'd0);
    chk("t7_rst_busy", 32'(busy), 32'd0);
    chk("t7_rst_en", 32'(fir_en), 32'd0);
    chk("t7_rst_xin", 32'(fir_xin), 32'd0);
    chk("t7_rst_mvalid", 32'(mif.m_valid), 32'd0);
    chk("t7_rst_mdata", 32'(mif.m_data), 32'd0);
    chk("t7_rst_ovf", 32'(ovf), 32'd0);
    repeat (2) tick();
    rstn = 1'b1;
    mif.m_ready = 1'b1;
    mb = mv_cnt;
    repeat (10) tick();
    chk("t7_idle_after", 32'(state), 32'd0);
    chk("t7_ignored", 32'(mv_cnt - mb), 32'd0);

    chk_on = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fir_ctrl.md
# fir_ctrl

Run-time controller for the 16-tap symmetric FIR in the DSO capture path. Derives the FIR sample strobe from a programmable divider and registers ADC samples into the filter. Blanks the pipeline-fill outputs and hands filtered (or bypassed raw) samples downstream through a 2-entry valid/ready buffer. Its run/stop FSM drains the FIR pipeline cleanly before returning to idle.

## Interface
- DIV_W, 16, width of the sample divider
- FILL_CNT, 16, number of initial FIR outputs discarded after start (tap count)
- OUT_W, 20, FIR output width
- clk  in  1  clock
- rstn  in  1  reset; asynchronous, active-low
- start  in  1  single-cycle run request
- stop  in  1  single-cycle stop request
- bypass  in  1  raw-sample mode; sampled on accepted start
- div  in  DIV_W  strobe period minus one; sampled on accepted start
- adc_data  in  8  ADC sample
- fir_en  out  1  FIR input-valid strobe
- fir_xin  out  8  registered sample to FIR
- fir_valid  in  1  FIR output valid; exactly one per fir_en
- fir_yout  in  OUT_W  FIR output
- m_valid  out  1  output sample valid
- m_ready  in  1  downstream accept
- m_data  out  OUT_W  output sample
- ovf  out  1  sticky: sample dropped on full buffer
- busy  out  1  state != IDLE
- state  out  2  IDLE=0, FILL=1, RUN=2, DRAIN=3

## Operation
- IDLE: no strobes. start latches div_q, byp_q, clears ovf, fill counter, divider counter -> FILL (byp_q=0) or RUN (byp_q=1). stop ignored in IDLE; start ignored outside IDLE.
- Divider (FILL, RUN): cnt increments each cycle; when cnt==div_q, fir_en=1 for one cycle, fir_xin<=adc_data same edge, cnt<=0. div_q=0 -> strobe every cycle.
- Outstanding counter (4 bit): +1 on fir_en, -1 on fir_valid, both same cycle -> unchanged.
- FILL: fir_valid increments fill counter; data discarded. On FILL_CNT-th fir_valid -> RUN.
- RUN, byp_q=0: fir_valid pushes fir_yout into buffer. RUN, byp_q=1: each strobe pushes {adc_data, 12'b0} directly; fir_en still issued.
- stop in FILL or RUN -> DRAIN; stop beats a strobe in the same cycle (no strobe issued).
- DRAIN: no new strobes; fir_valid pushed only if fill had completed, else discarded. Exit to IDLE when outstanding==0 and buffer empty.
- Buffer: 2-entry FIFO, push on qualifying event, pop on m_valid&&m_ready. Push when full (and no pop same cycle) drops the sample and sets ovf. Push+pop same cycle when full is accepted.
- m_data is the head entry, registered; stable while m_valid&&!m_ready.

## Timing
- Reset: fir_en=0, fir_xin=0, m_valid=0, m_data=0, ovf=0, busy=0, state=IDLE; buffer, counters, div_q, byp_q cleared.
- Start accepted at edge T: state/busy change at T; first fir_en high in cycle after T+div_q.
- Push at edge T -> m_valid high from T when buffer was empty (one-cycle latency from fir_valid).
- Full throughput one sample/cycle with m_ready held high.
- Reset mid-operation: immediate return to reset values; any in-flight FIR results arriving after reset are ignored in IDLE.
- fir_valid in IDLE is ignored; outstanding counter saturates at 0.

## Test plan
- div=3, bypass=0, m_ready=1, start: fir_en every 4 cycles; first 16 fir_valid discarded; 17th output appears on m_data one cycle after its fir_valid; state 1->2.
- div=0, bypass=1, adc_data ramp 0..9: m_data = {n,12'b0} each cycle in order, no fill blanking, state goes 0->2.
- m_ready=0 during RUN with div=0: two samples held, third dropped, ovf=1; m_ready=1 releases the two oldest samples in order; ovf stays 1 until next start.
- stop during RUN with 3 outstanding FIR results and m_ready=1: no further fir_en; all 3 delivered; IDLE once outstanding=0 and buffer empty.
- stop during FILL after 5 fir_valid: DRAIN, remaining results discarded, m_valid never asserts, return to IDLE.
- start and stop in the same cycle from IDLE: start wins. Assert rstn low in RUN with full buffer: all outputs at reset values immediately.
